// File: rtl/vx_execute_arb.sv
// vx_execute_arb
// Packet-aware arbiter that feeds one execute port from NUM_REQS requesters.
// Requesters that are not inside a packet are served round-robin. Once a
// multi-beat packet opens, its owner holds the port until the beat marked
// eop is accepted, so packets are never interleaved. A single registered
// output stage carries the granted beat downstream. A sticky flag reports
// sop/eop framing violations, and the beat that caused it is still forwarded.

`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module vx_execute_arb #(
    parameter int  NUM_REQS   = 4,
    parameter int  DATA_WIDTH = 256,
    localparam int REQ_SEL_W  = `LOG2UP(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            valid_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQS-1:0]            sop_in,
    input  logic [NUM_REQS-1:0]            eop_in,
    output logic [NUM_REQS-1:0]            ready_in,
    output logic                           valid_out,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           sop_out,
    output logic                           eop_out,
    output logic [REQ_SEL_W-1:0]           sel_out,
    input  logic                           ready_out,
    output logic                           proto_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,   // no packet open, round-robin grant
        ST_LOCKED = 1'b1    // packet open, only the owner is granted
    } state_t;

    state_t               state;
    logic [REQ_SEL_W-1:0] owner;
    logic [REQ_SEL_W-1:0] rr_ptr;

    // The output register can take a new beat when it is empty or draining.
    logic                 load;

    // Round-robin search result.
    int                   rr_cand;
    logic [REQ_SEL_W-1:0] rr_cand_idx;
    logic                 rr_found;
    logic [REQ_SEL_W-1:0] rr_idx;

    // Grant for this cycle and the fields of the granted beat.
    logic                  grant_valid;
    logic [REQ_SEL_W-1:0]  grant_idx;
    logic                  accept;
    logic                  acc_sop;
    logic                  acc_eop;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [REQ_SEL_W-1:0]  rr_next;

    assign load = !valid_out || ready_out;

    // Find the first valid requester at or after rr_ptr, wrapping at NUM_REQS.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        rr_cand     = 0;
        rr_cand_idx = '0;
        rr_found    = 1'b0;
        rr_idx      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            rr_cand     = (int'(rr_ptr) + k) % NUM_REQS;
            rr_cand_idx = REQ_SEL_W'(rr_cand);
            if (!rr_found && valid_in[rr_cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand_idx;
            end
        end
    end

    // Pick the granted requester: the owner while locked, the round-robin winner otherwise.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (state == ST_LOCKED) begin
            grant_idx   = owner;
            grant_valid = valid_in[owner];
        end else begin
            grant_idx   = rr_idx;
            grant_valid = rr_found;
        end
    end

    // A beat moves only when the output stage can load and reset is not active.
    assign accept = grant_valid && load && !reset;

    // Route the granted requester's payload and markers toward the output stage.
    always_comb begin
        acc_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == REQ_SEL_W'(i)) begin
                acc_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign acc_sop = sop_in[grant_idx];
    assign acc_eop = eop_in[grant_idx];
    assign rr_next = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;

    // Handshake back to the requesters: at most the granted one sees ready.
    always_comb begin
        ready_in = '0;
        if (accept) begin
            ready_in[grant_idx] = 1'b1;
        end
    end

    // Packet framing FSM with round-robin pointer and sticky protocol flag.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else if (accept) begin
            if (acc_eop) begin
                rr_ptr <= rr_next;
            end
            case (state)
                ST_IDLE: begin
                    if (!acc_sop) begin
                        proto_err <= 1'b1;
                    end
                    if (acc_sop && !acc_eop) begin
                        state <= ST_LOCKED;
                        owner <= grant_idx;
                    end
                end
                ST_LOCKED: begin
                    if (acc_sop) begin
                        proto_err <= 1'b1;
                    end
                    if (acc_eop) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output stage control: load on acceptance, drain when downstream takes the beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            sel_out   <= '0;
        end else if (load) begin
            valid_out <= accept;
            if (accept) begin
                sop_out <= acc_sop;
                eop_out <= acc_eop;
                sel_out <= grant_idx;
            end
        end
    end

    // Output payload register, written only when a beat is accepted.
    // NOTE: the wide payload is deliberately left out of reset; it is only
    // meaningful while valid_out is set, and skipping reset keeps it a plain
    // enable flop.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_out <= acc_data;
        end
    end

    // Sanity checks on the arbiter's own handshake behaviour.
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(ready_in));

    a_ready_needs_load: assert property (@(posedge clk) disable iff (reset)
        (|ready_in) |-> load);

    a_hold_when_stalled: assert property (@(posedge clk) disable iff (reset)
        (valid_out && !ready_out) |=> (valid_out && $stable(data_out) &&
            $stable(sel_out) && $stable(sop_out) && $stable(eop_out)));

endmodule

// File: tb/tb_vx_execute_arb.sv
// tb_vx_execute_arb
// Directed vector table for round-robin, packet lock, bubbles and framing
// errors; hand sequences for output stall and reset mid-packet; then random
// traffic against a behavioural model of the arbitration rules.

module tb_vx_execute_arb;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    valid_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    sop_in;
    logic [N-1:0]    eop_in;
    logic [N-1:0]    ready_in;
    logic            valid_out;
    logic [DW-1:0]   data_out;
    logic            sop_out;
    logic            eop_out;
    logic [1:0]      sel_out;
    logic            ready_out;
    logic            proto_err;

    int checks = 0;
    int errors = 0;

    vx_execute_arb #(
        .NUM_REQS   (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .sel_out   (sel_out),
        .ready_out (ready_out),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] sop;
        logic [3:0] eop;
        logic       rdy;
        logic [3:0] exp_rin;
        logic       exp_v;
        logic [1:0] exp_sel;
        logic       exp_sop;
        logic       exp_eop;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] s,
                                input logic [3:0] e, input logic rd, input logic [3:0] rin,
                                input logic ev, input logic [1:0] es, input logic eso,
                                input logic eeo, input logic eer);
        vec_t t;
        t.rst = r; t.valid = v; t.sop = s; t.eop = e; t.rdy = rd;
        t.exp_rin = rin; t.exp_v = ev; t.exp_sel = es;
        t.exp_sop = eso; t.exp_eop = eeo; t.exp_err = eer;
        return t;
    endfunction

    function automatic logic [31:0] dword(input int req, input int tag);
        return 32'hA000_0000 | 32'(req << 20) | 32'(tag & 16'hFFFF);
    endfunction

    task automatic set_data(input int tag);
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = dword(i, tag);
    endtask

    // NOTE: stimulus is driven with blocking assignments at the falling edge,
    // half a period away from the edge where the DUT samples it.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] s,
                         input logic [3:0] e, input logic rd, input int tag);
        @(negedge clk);
        reset = r; valid_in = v; sop_in = s; eop_in = e; ready_out = rd;
        set_data(tag);
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state: an open-packet owner of -1 means no packet open.
    logic        m_v, m_sop, m_eop, m_err;
    logic [31:0] m_data;
    int          m_sel, m_ptr, m_owner;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; valid_in = '0; sop_in = '0; eop_in = '0; ready_out = 1'b1;
        data_in = '0;
        repeat (2) @(negedge clk);

        // rst valid  sop    eop    rdy  rin    v  sel  sop eop err
        vecs.push_back(mk(1, 4'hF, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 0)); // ready_in low in reset
        vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 1, 0)); // rr 0,1,2,3,0
        vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 4'h4, 1, 2, 1, 1, 0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 4'h8, 1, 3, 1, 1, 0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4'h7, 4'h7, 4'h5, 1, 4'h2, 1, 1, 1, 0, 0)); // req1 3-beat packet
        vecs.push_back(mk(0, 4'h7, 4'h5, 4'h5, 1, 4'h2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4'h7, 4'h5, 4'h7, 1, 4'h2, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h5, 4'h5, 4'h5, 1, 4'h4, 1, 2, 1, 1, 0)); // then req2
        vecs.push_back(mk(0, 4'h2, 4'h2, 4'h0, 1, 4'h2, 1, 1, 1, 0, 0)); // req1 opens packet
        vecs.push_back(mk(0, 4'hD, 4'hD, 4'hD, 1, 4'h0, 0, 0, 0, 0, 0)); // owner bubble
        vecs.push_back(mk(0, 4'hD, 4'hD, 4'hD, 1, 4'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hF, 4'hD, 4'hF, 1, 4'h2, 1, 1, 0, 1, 0)); // req1 resumes, eop
        vecs.push_back(mk(0, 4'h8, 4'h0, 4'h8, 1, 4'h8, 1, 3, 0, 1, 1)); // req3 sop=0 in idle
        vecs.push_back(mk(0, 4'h1, 4'h1, 4'h1, 1, 4'h1, 1, 0, 1, 1, 1)); // flag is sticky
        vecs.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 1)); // drains, idle
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0)); // reset clears flag

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].sop, vecs[i].eop, vecs[i].rdy, i);
            check($sformatf("vec%0d_ready_in", i), 32'(ready_in), 32'(vecs[i].exp_rin));
            after_edge();
            check($sformatf("vec%0d_valid_out", i), 32'(valid_out), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v || vecs[i].rst) begin
                check($sformatf("vec%0d_sel_out", i), 32'(sel_out), 32'(vecs[i].exp_sel));
                check($sformatf("vec%0d_sop_out", i), 32'(sop_out), 32'(vecs[i].exp_sop));
                check($sformatf("vec%0d_eop_out", i), 32'(eop_out), 32'(vecs[i].exp_eop));
            end
            check($sformatf("vec%0d_proto_err", i), 32'(proto_err), 32'(vecs[i].exp_err));
        end

        // Output stall: the held beat must not move while ready_out is low.
        drive(0, 4'h2, 4'h2, 4'h2, 1, 1);
        check("stall_load_ready_in", 32'(ready_in), 32'h2);
        after_edge();
        check("stall_load_data", data_out, dword(1, 1));
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'hF, 4'hF, 4'hF, 0, 10 + c);
            check($sformatf("stall%0d_ready_in", c), 32'(ready_in), 32'h0);
            after_edge();
            check($sformatf("stall%0d_valid_out", c), 32'(valid_out), 32'h1);
            check($sformatf("stall%0d_sel_out", c), 32'(sel_out), 32'h1);
            check($sformatf("stall%0d_data_out", c), data_out, dword(1, 1));
        end
        drive(0, 4'hF, 4'hF, 4'hF, 1, 20);
        check("unstall_ready_in", 32'(ready_in), 32'h4);
        after_edge();
        check("unstall_sel_out", 32'(sel_out), 32'h2);
        check("unstall_data_out", data_out, dword(2, 20));

        // Reset in the middle of a req2 packet abandons it.
        drive(0, 4'h4, 4'h4, 4'h0, 1, 30);
        check("rstpkt_open_ready_in", 32'(ready_in), 32'h4);
        after_edge();
        drive(1, 4'h4, 4'h0, 4'h0, 1, 31);
        check("rstpkt_reset_ready_in", 32'(ready_in), 32'h0);
        after_edge();
        check("rstpkt_valid_out", 32'(valid_out), 32'h0);
        drive(0, 4'h5, 4'h1, 4'h1, 1, 40);
        check("rstpkt_first_grant", 32'(ready_in), 32'h1);
        after_edge();
        check("rstpkt_sel_out", 32'(sel_out), 32'h0);
        check("rstpkt_data_out", data_out, dword(0, 40));
        check("rstpkt_proto_err", 32'(proto_err), 32'h0);

        // Random traffic against the behavioural model.
        drive(1, 4'h0, 4'h0, 4'h0, 1, 0);
        after_edge();
        m_v = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0; m_data = '0;
        m_sel = 0; m_ptr = 0; m_owner = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       load, acc;
            logic [3:0] exp_rin;
            int         g;
            @(negedge clk);
            reset     = ($urandom_range(0, 99) == 0);
            valid_in  = 4'($urandom);
            sop_in    = 4'($urandom);
            eop_in    = 4'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) data_in[i*DW +: DW] = $urandom;
            #1;
            load = !m_v || ready_out;
            g = -1;
            if (m_owner >= 0) begin
                if (valid_in[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && valid_in[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            acc = !reset && load && (g >= 0);
            exp_rin = acc ? (4'b0001 << g) : 4'b0000;
            check("rand_ready_in", 32'(ready_in), 32'(exp_rin));
            if (reset) begin
                m_v = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0;
                m_sel = 0; m_ptr = 0; m_owner = -1;
            end else begin
                if (load) m_v = acc;
                if (acc) begin
                    m_sel  = g;
                    m_data = data_in[g*DW +: DW];
                    m_sop  = sop_in[g];
                    m_eop  = eop_in[g];
                    if (m_owner < 0) begin
                        if (!sop_in[g]) m_err = 1'b1;
                        if (sop_in[g] && !eop_in[g]) m_owner = g;
                    end else begin
                        if (sop_in[g]) m_err = 1'b1;
                        if (eop_in[g]) m_owner = -1;
                    end
                    if (eop_in[g]) m_ptr = (g + 1) % N;
                end
            end
            after_edge();
            check("rand_valid_out", 32'(valid_out), 32'(m_v));
            check("rand_proto_err", 32'(proto_err), 32'(m_err));
            if (m_v) begin
                check("rand_sel_out", 32'(sel_out), 32'(m_sel));
                check("rand_data_out", data_out, m_data);
                check("rand_sop_out", 32'(sop_out), 32'(m_sop));
                check("rand_eop_out", 32'(eop_out), 32'(m_eop));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
